// File: rtl/ex_stage_mc.sv
// Execute stage: forwarding, single-cycle ALU, iterative multiply.
// Define EX_DIV_EN to add the iterative unsigned divide (DIVU/REMU).
module ex_stage_mc #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MUL_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_link,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic              fwd_mem_we,
  input  logic [XLEN-1:0]   fwd_mem_val,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic              fwd_wb_we,
  input  logic [XLEN-1:0]   fwd_wb_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_res,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              out_cond,
  output logic              busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef EX_DIV_EN
    DIV,
`endif
    MUL
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   a_q, b_q, acc;
  logic [REG_AW-1:0] rd_q;
  logic              we_q;

  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [XLEN-1:0] b_dig, mul_nx;
  logic            alu_cond, accept, is_mul;
  logic [SHW-1:0]  sh;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign is_mul   = !in_link && (in_op == 4'd12);
  assign sh       = op_b[SHW-1:0];

  // MEM wins over WB; x0 is never forwarded
  always_comb begin
    op_a = in_rs1_val;
    if (in_rs1 != '0 && fwd_mem_we && fwd_mem_rd == in_rs1)
      op_a = fwd_mem_val;
    else if (in_rs1 != '0 && fwd_wb_we && fwd_wb_rd == in_rs1)
      op_a = fwd_wb_val;
    op_b = in_rs2_val;
    if (in_use_imm)
      op_b = in_imm;
    else if (in_rs2 != '0 && fwd_mem_we && fwd_mem_rd == in_rs2)
      op_b = fwd_mem_val;
    else if (in_rs2 != '0 && fwd_wb_we && fwd_wb_rd == in_rs2)
      op_b = fwd_wb_val;
  end

  always_comb begin
    alu_res  = '0;
    alu_cond = 1'b0;
    case (in_op)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a & op_b;
      4'd3:  alu_res = op_a | op_b;
      4'd4:  alu_res = op_a ^ op_b;
      4'd5:  alu_res = op_a << sh;
      4'd6:  alu_res = op_a >> sh;
      4'd7:  alu_res = $unsigned($signed(op_a) >>> sh);
      4'd8:  alu_res = {{(XLEN-1){1'b0}},
                        $signed(op_a) < $signed(op_b)};
      4'd9:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd10: alu_cond = (op_a == op_b);
      4'd11: alu_cond = (op_a != op_b);
      default: alu_res = '0;
    endcase
    if (in_link) begin
      alu_res  = in_pc;
      alu_cond = 1'b0;
    end
  end

  // one radix-2^MUL_STEP digit of B per cycle
  assign b_dig  = XLEN'(b_q[MUL_STEP-1:0]);
  assign mul_nx = acc + a_q * b_dig;

`ifdef EX_DIV_EN
  logic            is_div, rem_sel, div_ge;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic [XLEN-1:0] rem_nx, quo_nx;
  assign is_div  = !in_link && (in_op == 4'd13 || in_op == 4'd14);
  assign rem_sh  = {acc, a_q[XLEN-1]};
  assign div_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign rem_nx  = div_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {a_q[XLEN-2:0], div_ge};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
      out_cond  <= 1'b0;
`ifdef EX_DIV_EN
      rem_sel   <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          rd_q <= in_rd;
          we_q <= in_we;
          cnt  <= '0;
          a_q  <= op_a;
          b_q  <= op_b;
          acc  <= '0;
          if (is_mul) begin
            state <= MUL;
`ifdef EX_DIV_EN
          end else if (is_div) begin
            state   <= DIV;
            rem_sel <= (in_op == 4'd14);
`endif
          end else begin
            out_valid <= 1'b1;
            out_res   <= alu_res;
            out_cond  <= alu_cond;
            out_rd    <= in_rd;
            out_we    <= in_we;
          end
        end
        MUL: begin
          acc <= mul_nx;
          a_q <= a_q << MUL_STEP;
          b_q <= b_q >> MUL_STEP;
          cnt <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_res   <= mul_nx;
            out_cond  <= 1'b0;
            out_rd    <= rd_q;
            out_we    <= we_q;
          end
        end
`ifdef EX_DIV_EN
        DIV: begin
          acc <= rem_nx;
          a_q <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_res   <= rem_sel ? rem_nx : quo_nx;
            out_cond  <= 1'b0;
            out_rd    <= rd_q;
            out_we    <= we_q;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc (default params).
// Build with +define+EX_DIV_EN to exercise the divider.
module tb_ex_stage_mc;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [3:0]      in_op;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic            in_use_imm, in_we, in_link;
  logic [AW-1:0]   fwd_mem_rd, fwd_wb_rd;
  logic            fwd_mem_we, fwd_wb_we;
  logic [XLEN-1:0] fwd_mem_val, fwd_wb_val;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_res;
  logic [AW-1:0]   out_rd;
  logic            out_we, out_cond, busy;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [AW-1:0]   rd;
    logic            we;
    logic            cond;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_stage_mc dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_rd(in_rd), .in_we(in_we), .in_link(in_link),
    .in_pc(in_pc),
    .fwd_mem_rd(fwd_mem_rd), .fwd_mem_we(fwd_mem_we),
    .fwd_mem_val(fwd_mem_val),
    .fwd_wb_rd(fwd_wb_rd), .fwd_wb_we(fwd_wb_we),
    .fwd_wb_val(fwd_wb_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_rd(out_rd), .out_we(out_we),
    .out_cond(out_cond), .busy(busy)
  );

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic c;
    r = '0;
    c = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9:  r = (a < b) ? 1 : 0;
      4'd10: c = (a == b);
      4'd11: c = (a != b);
      4'd12: r = a * b;
`ifdef EX_DIV_EN
      4'd13: r = (b == 0) ? '1 : a / b;
      4'd14: r = (b == 0) ? a : a % b;
`endif
      default: r = '0;
    endcase
    return {r, 5'd7, 1'b1, c};
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0;
    in_rs1_val = 0; in_rs2_val = 0; in_imm = 0;
    in_use_imm = 0; in_rd = 0; in_we = 0; in_link = 0;
    in_pc = 0; fwd_mem_rd = 0; fwd_mem_we = 0;
    fwd_mem_val = 0; fwd_wb_rd = 0; fwd_wb_we = 0;
    fwd_wb_val = 0;
  endtask

  task automatic set_instr(input logic [3:0] op,
                           input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b,
                           input logic use_imm,
                           input logic link,
                           input logic [XLEN-1:0] pc);
    in_op = op; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_rs1_val = a;
    in_rs2_val = use_imm ? 32'h0 : b;
    in_imm = use_imm ? b : 32'h0;
    in_use_imm = use_imm; in_link = link; in_pc = pc;
    in_rd = 5'd7; in_we = 1'b1;
  endtask

  // handshake the currently driven instruction; bounded wait
  task automatic accept();
    bit ok;
    ok = 0;
    in_valid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept: in_ready=0 required 1");
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // wait for out_valid (out_ready assumed 1); n = idle cycles seen
  task automatic wait_out(output int n, output exp_t got);
    n = -1;
    got = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        got = {out_res, out_rd, out_we, out_cond};
        break;
      end
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL wait_out: out_valid=0 required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_res, out_rd, out_we, out_cond, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outs: v=%b res=%h rd=%h we=%b c=%b busy=%b required all 0",
               out_valid, out_res, out_rd, out_we, out_cond, busy);
    end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_imm();
    int n; exp_t got, e;
    sb.delete();
    set_instr(4'd0, 32'd5, 32'd7, 1, 0, 0);
    in_rs1 = 5'd3;
    sb.push_back({32'd12, 5'd7, 1'b1, 1'b0});
    accept();
    wait_out(n, got);
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL add_latency: got %0d required 0", n);
    end
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL add_imm: got %h required %h", got, e);
    end
  endtask

  task automatic test_forwarding();
    int n; exp_t got, e;
    logic [XLEN-1:0] want [4];
    sb.delete();
    want = '{32'h10, 32'h20, 32'h0, 32'h35};
    for (int k = 0; k < 4; k++) begin
      set_instr(4'd0, 32'h30, 32'h0, 0, 0, 0);
      in_rs1 = (k == 2) ? 5'd0 : 5'd4;
      in_rs1_val = (k == 2) ? 32'h0 : 32'h30;
      fwd_mem_rd = in_rs1; fwd_mem_we = (k != 1);
      fwd_mem_val = 32'h10;
      fwd_wb_rd = in_rs1; fwd_wb_we = 1; fwd_wb_val = 32'h20;
      if (k == 3) begin
        // rs2 forwarded from WB only, rs1 from regfile
        in_rs2 = 5'd6; fwd_mem_rd = 5'd9; fwd_wb_rd = 5'd6;
        in_rs2_val = 32'h99; fwd_wb_val = 32'h5;
      end
      sb.push_back({want[k], 5'd7, 1'b1, 1'b0});
      accept();
      fwd_mem_we = 0; fwd_wb_we = 0;
      wait_out(n, got);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL fwd_%0d: got %h required %h", k, got, e);
      end
    end
  endtask

  task automatic test_mul();
    int n; exp_t got, e;
    sb.delete();
    set_instr(4'd12, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    sb.push_back({32'hFFFF_FFFE, 5'd7, 1'b1, 1'b0});
    accept();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        errors++;
        $display("FAIL mul_busy_%0d: busy/rdy/vld=%b required 100",
                 i, {busy, in_ready, out_valid});
      end
    end
    wait_out(n, got);
    e = sb.pop_front();
    checks++;
    if (n != 0 || got !== e) begin
      errors++;
      $display("FAIL mul_wrap: n=%0d got %h required n=0 %h", n, got, e);
    end
    set_instr(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    sb.push_back(model(4'd12, 32'h1234_5678, 32'h9ABC_DEF0));
    accept();
    // forwarding changes during the op must not matter
    fwd_mem_rd = 5'd1; fwd_mem_we = 1; fwd_mem_val = 32'hDEAD;
    in_rs1_val = 32'h7;
    wait_out(n, got);
    fwd_mem_we = 0;
    e = sb.pop_front();
    checks++;
    if (n != 8 || got !== e) begin
      errors++;
      $display("FAIL mul_big: n=%0d got %h required n=8 %h", n, got, e);
    end
  endtask

  task automatic test_backpressure();
    exp_t got, e;
    sb.delete();
    out_ready = 0;
    set_instr(4'd1, 32'd10, 32'd3, 0, 0, 0);
    sb.push_back({32'd7, 5'd7, 1'b1, 1'b0});
    accept();
    set_instr(4'd4, 32'hF0, 32'hFF, 0, 0, 0);
    sb.push_back(model(4'd4, 32'hF0, 32'hFF));
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_res, in_ready} !== {1'b1, 32'd7, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: v=%b res=%h rdy=%b required 1 7 0",
                 i, out_valid, out_res, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready: got %b required 1", in_ready);
    end
    got = {out_res, out_rd, out_we, out_cond};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL bp_sub: got %h required %h", got, e);
    end
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    got = {out_res, out_rd, out_we, out_cond};
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL bp_next: v=%b got %h required 1 %h", out_valid, got, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cond_link();
    int n; exp_t got, e;
    logic [3:0]      ops [4];
    logic [XLEN-1:0] bs [4];
    sb.delete();
    ops = '{4'd10, 4'd11, 4'd10, 4'd10};
    bs  = '{32'd9, 32'd9, 32'd8, 32'd9};
    for (int k = 0; k < 4; k++) begin
      set_instr(ops[k], 32'd9, bs[k], 0, k == 3, 32'h100);
      if (k == 3) sb.push_back({32'h100, 5'd7, 1'b1, 1'b0});
      else sb.push_back(model(ops[k], 32'd9, bs[k]));
      accept();
      wait_out(n, got);
      e = sb.pop_front();
      checks++;
      if (n != 0 || got !== e) begin
        errors++;
        $display("FAIL cond_link_%0d: n=%0d got %h required %h",
                 k, n, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    set_instr(4'd12, 32'd3, 32'd5, 0, 0, 0);
    accept();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_mul: vld/busy/rdy=%b required 001",
               {out_valid, busy, in_ready});
    end
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mul_stale_%0d: out_valid=%b required 0",
                 i, out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int n; exp_t got, e;
    logic [3:0]      ops [4];
    logic [XLEN-1:0] bs [4];
    sb.delete();
    ops = '{4'd13, 4'd14, 4'd13, 4'd14};
    bs  = '{32'd7, 32'd0, 32'd0, 32'd7};
    for (int k = 0; k < 4; k++) begin
      set_instr(ops[k], 32'd100, bs[k], 0, 0, 0);
      sb.push_back(model(ops[k], 32'd100, bs[k]));
      accept();
      wait_out(n, got);
      e = sb.pop_front();
      checks++;
`ifdef EX_DIV_EN
      if (n != 32 || got !== e) begin
`else
      if (n != 0 || got !== e) begin
`endif
        errors++;
        $display("FAIL div_%0d: n=%0d got %h required %h", k, n, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    logic [3:0]      op;
    logic [XLEN-1:0] a, b;
    logic            ui;
    sb.delete();
    out_ready = 1;
    for (int i = 0; i <= 24; i++) begin
      if (i < 24) begin
        op = 4'($urandom_range(0, 11));
        a = $urandom;
        b = (i % 5 == 0) ? a : $urandom;
        ui = 1'($urandom_range(0, 1));
        if (op == 4'd12) op = 4'd15;
        set_instr(op, a, b, ui, 0, 0);
        sb.push_back(model(op, a, b));
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      @(negedge clk);
      if (i < 24) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_%0d: got 0 required 1", i);
        end
      end
      if (i > 0) begin
        got = {out_res, out_rd, out_we, out_cond};
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || got !== e) begin
          errors++;
          $display("FAIL b2b_%0d: v=%b got %h required 1 %h",
                   i, out_valid, got, e);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_imm();
    test_forwarding();
    test_mul();
    test_backpressure();
    test_cond_link();
    test_reset_mid_mul();
    test_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised execute stage with valid/ready handshakes on input and output.
- Captures one decoded instruction and resolves operand hazards by forwarding from the MEM and WB stages.
- Executes single-cycle ALU ops, or an iterative multi-cycle multiply, and presents a registered result to the MEM stage.
- Sits between decode/regfile-read and MEM; stalls upstream while a multi-cycle op is in flight or the output is blocked.

Parameters:
- XLEN, 32, datapath width; must be a multiple of MUL_STEP.
- REG_AW, 5, register-index width; register 0 is hard zero and never forwarded.
- MUL_STEP, 4, multiplier bits retired per cycle; MUL iteration count = XLEN/MUL_STEP.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage accepts an instruction this cycle
- in_op  in  4  operation code (see Behaviour)
- in_rs1, in_rs2  in  REG_AW  source register indices
- in_rs1_val, in_rs2_val  in  XLEN  register-file read values
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  operand B = in_imm instead of rs2
- in_rd  in  REG_AW  destination index
- in_we  in  1  instruction writes rd
- in_link  in  1  result = in_pc (jump-and-link)
- in_pc  in  XLEN  instruction PC
- fwd_mem_rd, fwd_wb_rd  in  REG_AW  destination index of the MEM / WB stage instruction
- fwd_mem_we, fwd_wb_we  in  1  write enable of the MEM / WB stage instruction
- fwd_mem_val, fwd_wb_val  in  XLEN  forwarded value from MEM / WB
- out_valid  out  1  result valid
- out_ready  in  1  MEM stage accepts the result
- out_res  out  XLEN  result
- out_rd  out  REG_AW  destination index
- out_we  out  1  write enable
- out_cond  out  1  branch condition
- busy  out  1  multi-cycle op in progress

Behaviour:
- Reset: state IDLE. out_valid, out_res, out_rd, out_we, out_cond and busy all 0. in_ready is 1 once reset deasserts.
- Reset mid-MUL or mid-DIV aborts the op; the result is discarded.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An instruction is accepted when in_valid && in_ready.
  - The output holds stable while out_valid && !out_ready.
  - An output transfer and a new acceptance may occur in the same cycle; a back-to-back single-cycle stream runs at 1 instruction/cycle.
- Forwarding, evaluated combinationally at acceptance, per source operand:
  - If rs != 0 && fwd_mem_we && fwd_mem_rd == rs, use fwd_mem_val.
  - Else if rs != 0 && fwd_wb_we && fwd_wb_rd == rs, use fwd_wb_val.
  - Else use the regfile value. MEM has priority over WB.
- Ops (A = rs1, B = rs2 or imm):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = B[log2(XLEN)-1:0].
  - 8 SLT (signed), 9 SLTU: result = 1/0.
  - 10 EQ, 11 NE: out_cond = compare result, out_res = 0.
  - 12 MUL: low XLEN bits of A*B; wraps modulo 2^XLEN.
  - 13 DIVU, 14 REMU: see Optional Feature.
  - 15 reserved: out_res = 0.
  - out_cond = 0 for every op except EQ/NE.
- in_link overrides the op: out_res = in_pc, 1-cycle latency, out_cond = 0.
- Single-cycle latency: out_valid is asserted on the cycle after acceptance.
- MUL:
  - Enter state MUL, busy = 1.
  - Each cycle add (A << k*MUL_STEP) * B-digit to the accumulator, for XLEN/MUL_STEP cycles.
  - Then return to IDLE with out_valid = 1. Latency = XLEN/MUL_STEP + 1 cycles from acceptance (9 at defaults).
- States: IDLE, MUL, DIV (DIV only present under the macro). Transition back to IDLE when the iteration counter reaches its final count.
- Operands are captured at acceptance; changes on fwd_* during MUL/DIV have no effect.

Optional Feature:
- Macro: EX_DIV_EN.
- Defined: ops 13/14 enter state DIV and run a restoring unsigned division, 1 quotient bit/cycle, XLEN cycles, busy = 1. Latency XLEN+1 cycles. DIVU returns the quotient, REMU the remainder.
- Divide by zero: quotient = all ones, remainder = A.
- Undefined: ops 13/14 behave as reserved (out_res = 0, 1-cycle latency) and no DIV state or logic exists.

Test Plan:
- ADD, rs1 = 3 (val 5), imm = 7, use_imm = 1, out_ready = 1 -> next cycle out_valid = 1, out_res = 12, out_cond = 0.
- Forwarding priority: rs1 = 4, fwd_mem rd = 4 val 0x10, fwd_wb rd = 4 val 0x20, regfile 0x30, op ADD with B = 0 -> out_res = 0x10.
- Same case with rs1 = 0 and fwd rd = 0 -> out_res = 0, no forwarding.
- MUL 0xFFFFFFFF * 2 -> busy high 8 cycles, in_ready = 0 meanwhile, out_res = 0xFFFFFFFE at cycle 9.
- Backpressure: out_ready = 0 for 3 cycles after a SUB 10-3 -> out_res holds 7, in_ready = 0; out_ready = 1 -> transfer, and the next instruction is accepted the same cycle.
- EQ 9,9 -> out_cond = 1; NE 9,9 -> out_cond = 0. Link with in_pc = 0x100 -> out_res = 0x100.
- Reset asserted at MUL cycle 3 -> next cycle out_valid = 0, busy = 0, in_ready = 1.
- EX_DIV_EN defined: DIVU 100/7 -> 14 after 33 cycles; REMU 100/0 -> 100.
- EX_DIV_EN undefined: DIVU -> out_res = 0 after 1 cycle.
